// File: rtl/axi4_lite_resp_pkg.sv
// Shared types and helpers for the AXI4-Lite register responder:
// response codes, responder FSM states and the address decode rule.
package axi4_lite_resp_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Width of the response latency counter (latency range 0..1023)
   localparam int LAT_W = 10;

   typedef enum logic [2:0] {
      IDLE,
      WR_COLLECT,
      WR_WAIT,
      WR_RESP,
      RD_WAIT,
      RD_RESP
   } resp_state_e;

   // Classify an access. Out-of-window wins over misalignment, which wins
   // over a write to a read-only register. Addresses are zero-extended to
   // 64 bits; the below-base test runs first so the offset never wraps.
   function automatic logic [1:0] decode_resp(input logic [63:0] addr,
                                              input logic        is_write,
                                              input logic [63:0] base,
                                              input int unsigned num_regs,
                                              input logic        ro);
      logic [63:0] off;
      off = addr - base;
      if ((addr < base) || (off >= (64'(num_regs) * 64'd4))) return RESP_DECERR;
      if (addr[1:0] != 2'b00)                               return RESP_SLVERR;
      if (is_write && ro)                                   return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi4_lite_reg_file.sv
// NUM_REGS x 32-bit register storage with byte-strobe merge, read-only
// protection and a one-cycle write pulse per register.
module axi4_lite_reg_file #(
   parameter int                  NUM_REGS      = 16,
   parameter logic [NUM_REGS-1:0] READONLY_MASK = '0,
   localparam int                 IDXW          = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en_i,
   input  logic [IDXW-1:0]          wr_idx_i,
   input  logic [31:0]              wr_data_i,
   input  logic [3:0]               wr_strb_i,
   input  logic [IDXW-1:0]          rd_idx_i,
   output logic [31:0]              rd_data_o,
   output logic [NUM_REGS*32-1:0]   regs_o,
   output logic [NUM_REGS-1:0]      wr_pulse_o
);

   logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
   logic [NUM_REGS-1:0]       pulse_q, pulse_d;

   // Merge enabled byte lanes into the addressed register; read-only regs never change
   always_comb begin
      regs_d  = regs_q;
      pulse_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_en_i && (wr_idx_i == IDXW'(i)) && !READONLY_MASK[i]) begin
            pulse_d[i] = 1'b1;
            for (int b = 0; b < 4; b++) begin
               if (wr_strb_i[b]) regs_d[i][8*b +: 8] = wr_data_i[8*b +: 8];
            end
         end
      end
   end

   // Register storage and write pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q  <= '0;
         pulse_q <= '0;
      end else begin
         regs_q  <= regs_d;
         pulse_q <= pulse_d;
      end
   end

   // Read mux; an index past NUM_REGS reads zero
   always_comb begin
      rd_data_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx_i == IDXW'(i)) rd_data_o = regs_q[i];
      end
   end

   assign regs_o     = regs_q;
   assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/axi4_lite_reg_responder.sv
// AXI4-Lite subordinate terminating the UART-AXI4 bridge master port.
// One transaction in flight; response after RESP_LATENCY+1 cycles.
// Optional macro AXIUART_RESP_STALL_EN adds resp_stall, which freezes the
// latency counter and blocks new requests.
module axi4_lite_reg_responder
   import axi4_lite_resp_pkg::*;
#(
   parameter int                    ADDR_WIDTH    = 32,
   parameter int                    NUM_REGS      = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 'h1000,
   parameter int                    RESP_LATENCY  = 2,
   parameter logic [NUM_REGS-1:0]   READONLY_MASK = '0
) (
   input  logic                   clk,
   input  logic                   rst,
`ifdef AXIUART_RESP_STALL_EN
   input  logic                   resp_stall,
`endif
   input  logic [ADDR_WIDTH-1:0]  awaddr,
   input  logic                   awvalid,
   output logic                   awready,
   input  logic [31:0]            wdata,
   input  logic [3:0]             wstrb,
   input  logic                   wvalid,
   output logic                   wready,
   output logic [1:0]             bresp,
   output logic                   bvalid,
   input  logic                   bready,
   input  logic [ADDR_WIDTH-1:0]  araddr,
   input  logic                   arvalid,
   output logic                   arready,
   output logic [31:0]            rdata,
   output logic [1:0]             rresp,
   output logic                   rvalid,
   input  logic                   rready,
   output logic [NUM_REGS*32-1:0] reg_q,
   output logic [NUM_REGS-1:0]    reg_wr_pulse,
   output logic [15:0]            resp_err_count
);

   localparam int               IDXW = $clog2(NUM_REGS);
   localparam logic [LAT_W-1:0] LAT  = LAT_W'(RESP_LATENCY);

   resp_state_e           state_q, state_d;
   logic                  aw_got_q, aw_got_d, w_got_q, w_got_d, is_wr_q, is_wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d, rdata_q;
   logic [3:0]            wstrb_q, wstrb_d;
   logic [LAT_W-1:0]      cnt_q, cnt_d;
   logic [1:0]            resp_q, resp_d;
   logic [15:0]           err_q, err_d;
   logic                  aw_hs, w_hs, ar_hs, req_done, enter_resp, commit, rd_load;
   logic [IDXW-1:0]       idx;
   logic                  ro_bit;
   logic                  stall;
   logic [31:0]           rf_rd_data;

`ifdef AXIUART_RESP_STALL_EN
   assign stall = resp_stall;
`else
   assign stall = 1'b0;
`endif

   // Next-state, channel readys, capture muxes and response decode
   always_comb begin
      state_d    = state_q;
      aw_got_d   = aw_got_q;
      w_got_d    = w_got_q;
      is_wr_d    = is_wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      cnt_d      = cnt_q;
      resp_d     = resp_q;
      err_d      = err_q;
      awready    = 1'b0;
      wready     = 1'b0;
      arready    = 1'b0;
      req_done   = 1'b0;
      enter_resp = 1'b0;
      commit     = 1'b0;
      rd_load    = 1'b0;
      ro_bit     = 1'b0;

      // Readys are held low during reset so nothing is accepted then
      unique case (state_q)
         IDLE: begin
            if (!rst && !stall) begin
               awready = 1'b1;
               wready  = 1'b1;
               arready = !awvalid && !wvalid;
            end
         end
         WR_COLLECT: begin
            if (!rst) begin
               awready = !aw_got_q;
               wready  = !w_got_q;
            end
         end
         default: ;
      endcase

      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      ar_hs = arvalid && arready;

      if (aw_hs) begin
         addr_d   = awaddr;
         aw_got_d = 1'b1;
         is_wr_d  = 1'b1;
      end
      if (w_hs) begin
         wdata_d = wdata;
         wstrb_d = wstrb;
         w_got_d = 1'b1;
         is_wr_d = 1'b1;
      end
      if (ar_hs) begin
         addr_d  = araddr;
         is_wr_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if ((aw_hs && w_hs) || ar_hs) req_done = 1'b1;
            else if (aw_hs || w_hs)       state_d  = WR_COLLECT;
         end
         WR_COLLECT: begin
            if (aw_got_d && w_got_d) req_done = 1'b1;
         end
         WR_WAIT, RD_WAIT: begin
            if (!stall) begin
               if (cnt_q == '0) enter_resp = 1'b1;
               else             cnt_d      = cnt_q - 1'b1;
            end
         end
         WR_RESP: begin
            if (bready) state_d = IDLE;
         end
         RD_RESP: begin
            if (rready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // The counter holds cycles still to wait after this one, so the
      // response rises RESP_LATENCY+1 cycles after the final handshake.
      if (req_done) begin
         if ((LAT == '0) && !stall) begin
            enter_resp = 1'b1;
         end else begin
            state_d = is_wr_d ? WR_WAIT : RD_WAIT;
            cnt_d   = (LAT == '0) ? '0 : LAT - 1'b1;
         end
      end

      idx = IDXW'((addr_d - BASE_ADDR) >> 2);
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == IDXW'(i)) ro_bit = READONLY_MASK[i];
      end

      if (enter_resp) begin
         resp_d  = decode_resp(64'(addr_d), is_wr_d, 64'(BASE_ADDR), NUM_REGS, ro_bit);
         state_d = is_wr_d ? WR_RESP : RD_RESP;
         commit  = is_wr_d && (resp_d == RESP_OKAY);
         rd_load = !is_wr_d;
      end

      if ((state_q == WR_RESP && bready) || (state_q == RD_RESP && rready)) begin
         aw_got_d = 1'b0;
         w_got_d  = 1'b0;
         if (resp_q != RESP_OKAY && err_q != 16'hFFFF) err_d = err_q + 16'd1;
      end
   end

   // State and captured-request registers; read data sampled on entry to RD_RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         aw_got_q <= 1'b0;
         w_got_q  <= 1'b0;
         is_wr_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         cnt_q    <= '0;
         resp_q   <= RESP_OKAY;
         err_q    <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         aw_got_q <= aw_got_d;
         w_got_q  <= w_got_d;
         is_wr_q  <= is_wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         cnt_q    <= cnt_d;
         resp_q   <= resp_d;
         err_q    <= err_d;
         if (rd_load) rdata_q <= (resp_d == RESP_OKAY) ? rf_rd_data : '0;
      end
   end

   axi4_lite_reg_file #(
      .NUM_REGS      (NUM_REGS),
      .READONLY_MASK (READONLY_MASK)
   ) u_reg_file (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (commit),
      .wr_idx_i   (idx),
      .wr_data_i  (wdata_d),
      .wr_strb_i  (wstrb_d),
      .rd_idx_i   (idx),
      .rd_data_o  (rf_rd_data),
      .regs_o     (reg_q),
      .wr_pulse_o (reg_wr_pulse)
   );

   assign bvalid         = (state_q == WR_RESP);
   assign rvalid         = (state_q == RD_RESP);
   assign bresp          = bvalid ? resp_q : RESP_OKAY;
   assign rresp          = rvalid ? resp_q : RESP_OKAY;
   assign rdata          = rdata_q;
   assign resp_err_count = err_q;

endmodule

// File: doc/axi4_lite_reg_responder.md
Name: axi4_lite_reg_responder

Overview:
- AXI4-Lite subordinate that terminates the transactions issued by the UART-AXI4 bridge master port. It holds a small 32-bit register file and returns OKAY/SLVERR/DECERR responses after a programmable latency.
- Serves as the bridge's standard register endpoint in system sims and on FPGA. The optional stall input lets benches drive the bridge's AXI transaction timeout path.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- NUM_REGS, 16, number of 32-bit registers (2..256).
- BASE_ADDR, 32'h0000_1000, byte address of reg 0; must be 4-byte aligned.
- RESP_LATENCY, 2, extra cycles between request capture and response valid (0..1023).
- READONLY_MASK, '0 (NUM_REGS bits), bit i=1 makes reg i read-only.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- awaddr  in  ADDR_WIDTH  write address.
- awvalid/awready  in/out  1  AW handshake.
- wdata  in  32  write data.
- wstrb  in  4  byte strobes.
- wvalid/wready  in/out  1  W handshake.
- bresp  out  2  write response.
- bvalid/bready  out/in  1  B handshake.
- araddr  in  ADDR_WIDTH  read address.
- arvalid/arready  in/out  1  AR handshake.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rvalid/rready  out/in  1  R handshake.
- reg_q  out  NUM_REGS*32  flattened register contents; reg i at [32i+31:32i].
- reg_wr_pulse  out  NUM_REGS  one-cycle strobe on each successful commit to reg i.
- resp_err_count  out  16  saturating count of non-OKAY responses.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - all registers 0; state IDLE.
  - awready=wready=arready=0; bvalid=rvalid=0; bresp=rresp=0; rdata=0.
  - reg_wr_pulse=0; resp_err_count=0; any in-flight transaction is dropped without a response.
- One outstanding transaction at a time. FSM states: IDLE, WR_COLLECT, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP.
- IDLE:
  - awready=wready=1. Any awvalid or wvalid starts a write, which has priority over reads. Each channel that handshakes is captured; go to WR_COLLECT, or straight to WR_WAIT if both handshake in the same cycle.
  - arready = !awvalid && !wvalid. An AR handshake captures araddr and goes to RD_WAIT.
- WR_COLLECT: the channel already captured deasserts its ready; the remaining channel's ready stays 1. When it handshakes, go to WR_WAIT. AW and W may arrive in either order and any number of cycles apart.
- Latency counter:
  - loaded with RESP_LATENCY on entry to WR_WAIT/RD_WAIT and decremented each cycle.
  - at 0 the FSM moves to the RESP state.
  - bvalid/rvalid rise exactly RESP_LATENCY+1 cycles after the cycle of the final request handshake.
- Address decode:
  - offset = addr - BASE_ADDR.
  - addr < BASE_ADDR or offset >= 4*NUM_REGS -> DECERR (2'b11).
  - else addr[1:0] != 0 -> SLVERR (2'b10).
  - else write to a READONLY_MASK reg -> SLVERR.
  - else OKAY (2'b00).
- Write commit:
  - happens only on OKAY, in the cycle the FSM enters WR_RESP (bvalid first high).
  - byte lanes are merged per wstrb; wstrb=0 is OKAY with no change.
  - reg_wr_pulse[i] is high for that one cycle.
- Read data: sampled on entry to RD_RESP; rdata=0 for non-OKAY responses.
- RESP states: bvalid/rvalid, bresp/rresp and rdata stay stable until bready/rready. On the handshake, return to IDLE the following cycle; no back-to-back acceptance in the handshake cycle.
- resp_err_count: +1 on each B/R handshake with resp != OKAY; saturates at 16'hFFFF.
- Reads ignore READONLY_MASK.
- Arithmetic: offset computed at ADDR_WIDTH; index = offset[2+:$clog2(NUM_REGS)].

Optional Feature:
- AXIUART_RESP_STALL_EN defined:
  - adds input resp_stall (1 bit).
  - while high, the latency counter freezes, the FSM does not leave WR_WAIT/RD_WAIT, and IDLE deasserts all readys.
  - an already-asserted bvalid/rvalid is held unchanged.
- Undefined: port absent; behaviour as above.

Decomposition:
- Package axi4_lite_resp_pkg holds:
  - resp codes RESP_OKAY/RESP_SLVERR/RESP_DECERR (logic [1:0]);
  - FSM state enum resp_state_e;
  - function decode_resp(addr, is_write) helper.
- Sub-module axi4_lite_reg_file (NUM_REGS x 32 storage, strobe merge, read-only mask, wr_pulse). The responder FSM stays in the top.

Test Plan:
- AW then W 3 cycles later, awaddr=0x1004, wdata=0xDEADBEEF, wstrb=4'hF, RESP_LATENCY=2 -> bvalid 3 cycles after the W handshake, bresp=00, reg_q[1]=0xDEADBEEF, reg_wr_pulse[1] for one cycle.
- Read araddr=0x1004 with rready held low 5 cycles -> rvalid stable, rdata=0xDEADBEEF, rresp=00 throughout; IDLE one cycle after the handshake.
- araddr=0x2000 and awaddr=0x1002 -> DECERR with rdata=0, then SLVERR; resp_err_count=2; no reg change.
- Write wstrb=4'b0100, wdata=0x00AA0000 to reg 1 -> reg_q[1]=0xDEAABEEF; write to a READONLY_MASK reg -> SLVERR, value unchanged.
- awvalid and arvalid asserted together -> write completes first, then the read; rst pulsed while in RD_WAIT -> no rvalid, all outputs at reset values the next cycle.
- AXIUART_RESP_STALL_EN, resp_stall high 100 cycles during WR_WAIT -> bvalid low until release, then asserts after the remaining latency.
